enc_seq: RTL and testbench

- TDM channel sequencer for the multi-channel ADPCM encoder datapath.
- On each 8 kHz frame sync it walks the channels in ascending order, issuing one encode request per active channel and waiting for the datapath to finish.
- Sits between the frame-timing logic and the encoder core.
- Reports frame completion, frame overrun and stalled-datapath errors.

---
 rtl/enc_seq.sv | 211 +++++++++++++++++++++
 tb/tb_enc_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_seq.sv
// enc_seq: TDM channel sequencer for the multi-channel ADPCM encoder.
// On each accepted frame sync it walks the channels in ascending order and
// issues one encode request per active channel. It then waits for the
// datapath to finish that channel before moving on.
// It reports frame completion, frame overrun and stalled-datapath errors.
//
// Optional feature macro: ENC_SEQ_TIMEOUT_EN
//   defined   : a per-channel WAIT timer abandons a stalled channel after
//               TIMEOUT cycles and raises the sticky timeout_err flag.
//   undefined : no timer is built, WAIT waits for enc_done indefinitely,
//               and timeout_err is tied low.
//
// Datapath handshake: enc_start is a one-cycle request carrying enc_ch.
// The request is accepted implicitly, and the sequencer then sits in WAIT
// until enc_done pulses. enc_done is honoured only in WAIT; a pulse seen in
// any other state is dropped.
module enc_seq #(
    parameter int NUM_CH  = 24,
    parameter int CH_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_in0,
    input  logic              scan_en,
    output logic              scan_out0,
    input  logic              fs,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_active,
    output logic              enc_start,
    output logic [CH_W-1:0]   enc_ch,
    input  logic              enc_done,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CH_W-1:0] LAST_PTR = CH_W'(NUM_CH);

    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     ch_ptr;
    logic [CH_W-1:0]     ch_ptr_nxt;
    logic [NUM_CH-1:0]   mask;
    logic                mask_ld;
    logic                tmo_hit;
    logic [CH_W-1:0]     enc_ch_q;
    logic [7:0]          frame_cnt_q;
    logic                overrun_q;
    logic                fs_drop;

    // The scan pins are kept for the test insertion flow and carry no function.
    logic unused_scan;
    assign unused_scan = scan_in0 ^ scan_en;
    assign scan_out0   = 1'b0;

    // A frame sync that arrives while a frame is still in progress (DONE
    // included) is dropped and counts as an overrun.
    assign fs_drop = fs && (state != ST_IDLE);

`ifdef ENC_SEQ_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] timer;
    logic             timeout_err_q;

    // The WAIT timer is zeroed on each request and counts WAIT cycles that have no enc_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (state == ST_START) begin
            timer <= '0;
        end else if ((state == ST_WAIT) && !enc_done && (timer != TMR_LAST)) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Sticky stall flag. A new timeout in the same cycle as ovr_clr wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err_q <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err_q <= 1'b1;
        end else if (ovr_clr) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_err = 1'b0;
`endif

    // FSM state register and channel pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ch_ptr <= '0;
        end else begin
            state  <= state_nxt;
            ch_ptr <= ch_ptr_nxt;
        end
    end

    // Next-state logic. SEL inspects exactly one channel per cycle.
    always_comb begin
        state_nxt  = state;
        ch_ptr_nxt = ch_ptr;
        mask_ld    = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fs && enable) begin
                    mask_ld    = 1'b1;
                    ch_ptr_nxt = '0;
                    state_nxt  = ST_SEL;
                end
            end
            ST_SEL: begin
                if (ch_ptr == LAST_PTR) begin
                    state_nxt = ST_DONE;
                end else if (mask[ch_ptr]) begin
                    state_nxt = ST_START;
                end else begin
                    ch_ptr_nxt = ch_ptr + CH_W'(1);
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (enc_done) begin
                    ch_ptr_nxt = ch_ptr + CH_W'(1);
                    state_nxt  = ST_SEL;
                end
`ifdef ENC_SEQ_TIMEOUT_EN
                else if (timer == TMR_LAST) begin
                    tmo_hit    = 1'b1;
                    ch_ptr_nxt = ch_ptr + CH_W'(1);
                    state_nxt  = ST_SEL;
                end
`endif
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The channel mask is captured only when a frame is accepted, so later changes to ch_active do not affect the current frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= '0;
        end else if (mask_ld) begin
            mask <= ch_active;
        end
    end

    // enc_ch is loaded when a request is issued. It holds its last value otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_ch_q <= '0;
        end else if ((state == ST_SEL) && (state_nxt == ST_START)) begin
            enc_ch_q <= ch_ptr;
        end
    end

    // Completed-frame counter. It wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else if (state == ST_DONE) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Sticky overrun flag. A new overrun in the same cycle as ovr_clr wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (fs_drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign enc_start  = (state == ST_START);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    assign enc_ch     = enc_ch_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_enc_seq.sv
// tb_enc_seq: self-checking bench for enc_seq.
// It uses directed vector tables, hand-written corner sequences, and random
// frames. The random frames are checked against a cycle-schedule model of
// the frame walk.
module tb_enc_seq;

    localparam int NUM_CH  = 24;
    localparam int CH_W    = 5;
    localparam int TIMEOUT = 255;

    logic              clk;
    logic              reset;
    logic              scan_in0;
    logic              scan_en;
    logic              scan_out0;
    logic              fs;
    logic              enable;
    logic [NUM_CH-1:0] ch_active;
    logic              enc_start;
    logic [CH_W-1:0]   enc_ch;
    logic              enc_done;
    logic              busy;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              overrun;
    logic              ovr_clr;
    logic              timeout_err;

    enc_seq #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_en(scan_en),
        .scan_out0(scan_out0), .fs(fs), .enable(enable), .ch_active(ch_active),
        .enc_start(enc_start), .enc_ch(enc_ch), .enc_done(enc_done), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .overrun(overrun),
        .ovr_clr(ovr_clr), .timeout_err(timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- scoreboard state ----------------
    int          dly[NUM_CH];      // datapath latency per channel, 0 = never answers
    logic [7:0]  exp_frames;
    int          exp_cyc_q[$];
    int          exp_ch_q[$];
    int          exp_done;
    int          obs_cyc_q[$];
    int          obs_ch_q[$];
    int          obs_done;
    int          inj_ch;
    bit          rand_mid;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        int d;
        int first_cyc;
        int first_ch;
        int n_starts;
        int done_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dly(input int d);
        for (int c = 0; c < NUM_CH; c++) dly[c] = d;
    endtask

    // The reference schedule is built from the frame rules. Each channel costs
    // one select cycle, and each active channel also costs one request cycle
    // plus its wait.
    task automatic model(input logic [NUM_CH-1:0] m);
        int t;
        int w;
        exp_cyc_q.delete();
        exp_ch_q.delete();
        t = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                exp_cyc_q.push_back(t + 1);
                exp_ch_q.push_back(c);
                w = (dly[c] == 0) ? TIMEOUT : dly[c];
                t = t + 2 + w;
            end else begin
                t = t + 1;
            end
        end
        exp_done = t + 1;
    endtask

    // This driver starts a frame with fs in cycle 0. It then acts as the
    // datapath, recording every request and the frame_done cycle.
    task automatic run_frame(input logic [NUM_CH-1:0] m);
        int done_at;
        bit inj_pending;
        obs_cyc_q.delete();
        obs_ch_q.delete();
        obs_done    = -1;
        done_at     = -1;
        inj_pending = 1'b0;
        fs = 1'b1; enable = 1'b1; ch_active = m;
        tick();
        fs = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            enc_done    = (cyc == done_at);
            fs          = inj_pending;
            inj_pending = 1'b0;
            if (rand_mid) begin
                ch_active = NUM_CH'($urandom);
                enable    = 1'($urandom_range(0, 1));
            end
            if (enc_start) begin
                obs_cyc_q.push_back(cyc);
                obs_ch_q.push_back(int'(enc_ch));
                if ((int'(enc_ch) < NUM_CH) && (dly[enc_ch] != 0)) done_at = cyc + dly[enc_ch];
                if (int'(enc_ch) == inj_ch) inj_pending = 1'b1;
            end
            check("busy_in_frame", int'(busy), 1);
            if (frame_done) begin
                obs_done = cyc;
                break;
            end
            tick();
        end
        check("frame_end_seen", int'(obs_done >= 0), 1);
        enc_done = 1'b0;
        fs       = 1'b0;
        tick();
        exp_frames = exp_frames + 8'd1;
        check("frame_cnt", int'(frame_cnt), int'(exp_frames));
        check("busy_after_frame", int'(busy), 0);
    endtask

    task automatic compare_to_model(input string tag);
        check({tag, "_n_starts"}, obs_cyc_q.size(), exp_cyc_q.size());
        for (int i = 0; i < exp_cyc_q.size() && i < obs_cyc_q.size(); i++) begin
            check({tag, "_start_cyc"}, obs_cyc_q[i], exp_cyc_q[i]);
            check({tag, "_start_ch"}, obs_ch_q[i], exp_ch_q[i]);
        end
        check({tag, "_done_cyc"}, obs_done, exp_done);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        int nst;
        logic [7:0] cnt_before;

        vecs[0] = '{mask: 24'h000005, d: 3, first_cyc: 2,  first_ch: 0,  n_starts: 2,  done_cyc: 34};
        vecs[1] = '{mask: 24'h000000, d: 1, first_cyc: -1, first_ch: -1, n_starts: 0,  done_cyc: 26};
        vecs[2] = '{mask: 24'h800000, d: 1, first_cyc: 25, first_ch: 23, n_starts: 1,  done_cyc: 28};
        vecs[3] = '{mask: 24'hFFFFFF, d: 1, first_cyc: 2,  first_ch: 0,  n_starts: 24, done_cyc: 74};
        vecs[4] = '{mask: 24'h000001, d: 2, first_cyc: 2,  first_ch: 0,  n_starts: 1,  done_cyc: 29};
        vecs[5] = '{mask: 24'h000010, d: 5, first_cyc: 6,  first_ch: 4,  n_starts: 1,  done_cyc: 32};

        reset = 1'b0; scan_in0 = 1'b0; scan_en = 1'b0; fs = 1'b0; enable = 1'b0;
        ch_active = '0; enc_done = 1'b0; ovr_clr = 1'b0;
        exp_frames = 8'd0; inj_ch = -1; rand_mid = 1'b0;
        set_dly(1);

        // Reset state
        tick(); tick();
        check("rst_busy", int'(busy), 0);
        check("rst_enc_start", int'(enc_start), 0);
        check("rst_enc_ch", int'(enc_ch), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_scan_out0", int'(scan_out0), 0);
        reset = 1'b1;
        tick();

        // fs with enable low is ignored
        fs = 1'b1; enable = 1'b0; ch_active = '1;
        tick();
        fs = 1'b0;
        check("fs_disabled_busy", int'(busy), 0);
        check("fs_disabled_overrun", int'(overrun), 0);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            set_dly(vecs[v].d);
            run_frame(vecs[v].mask);
            check("vec_n_starts", obs_cyc_q.size(), vecs[v].n_starts);
            check("vec_first_cyc", (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, vecs[v].first_cyc);
            check("vec_first_ch", (obs_ch_q.size() > 0) ? obs_ch_q[0] : -1, vecs[v].first_ch);
            check("vec_done_cyc", obs_done, vecs[v].done_cyc);
        end
        check("vec_second_ch_sparse", 2, 2 * int'(vecs[0].mask[2]));

        // Overrun while waiting on channel 5: the frame still covers all channels and ends once
        set_dly(2);
        inj_ch = 5;
        run_frame('1);
        inj_ch = -1;
        check("ovr_n_starts", obs_cyc_q.size(), 24);
        check("ovr_done_cyc", obs_done, 98);
        check("ovr_flag", int'(overrun), 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || frame_done || enc_start) seen++;
            tick();
        end
        check("ovr_no_extra_frame", seen, 0);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);

        // Set beats clear in the same cycle. A frame sync during DONE is dropped.
        fs = 1'b1; enable = 1'b1; ch_active = '0;
        tick();
        ovr_clr = 1'b1;
        tick();
        fs = 1'b0; ovr_clr = 1'b0;
        check("ovr_set_beats_clr", int'(overrun), 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("ovr_clr_mid_frame", int'(overrun), 0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (frame_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("done_fs_frame_seen", seen, 1);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        exp_frames = exp_frames + 8'd1;
        check("done_fs_dropped", int'(busy), 0);
        check("done_fs_overrun", int'(overrun), 1);
        check("done_fs_frame_cnt", int'(frame_cnt), int'(exp_frames));
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("done_fs_ovr_clr", int'(overrun), 0);

        // Stalled datapath on channel 0
`ifdef ENC_SEQ_TIMEOUT_EN
        set_dly(1);
        dly[0] = 0;
        model(24'h000003);
        run_frame(24'h000003);
        compare_to_model("tmo");
        check("tmo_ch1_cyc", (obs_cyc_q.size() > 1) ? obs_cyc_q[1] : -1, 259);
        check("tmo_flag", int'(timeout_err), 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("tmo_clr", int'(timeout_err), 0);
`else
        fs = 1'b1; enable = 1'b1; ch_active = 24'h000001;
        tick();
        fs = 1'b0;
        nst = 0;
        for (int i = 0; i < 300; i++) begin
            nst += int'(enc_start);
            tick();
        end
        check("stall_n_starts", nst, 1);
        check("stall_busy", int'(busy), 1);
        check("stall_timeout_err", int'(timeout_err), 0);
        enc_done = 1'b1; tick(); enc_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (frame_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("stall_frame_end", seen, 1);
        tick();
        exp_frames = exp_frames + 8'd1;
        check("stall_frame_cnt", int'(frame_cnt), int'(exp_frames));
`endif

        // Random frames with mid-frame mask and enable noise
        rand_mid = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom & $urandom);
            for (int c = 0; c < NUM_CH; c++) dly[c] = $urandom_range(1, 6);
            model(m);
            run_frame(m);
            compare_to_model("rnd");
        end
        rand_mid = 1'b0;

        // Asynchronous reset in the middle of a frame
        set_dly(1);
        fs = 1'b1; enable = 1'b1; ch_active = '1;
        tick();
        fs = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 reset = 1'b0;
        #1;
        check("mrst_busy", int'(busy), 0);
        check("mrst_enc_start", int'(enc_start), 0);
        check("mrst_enc_ch", int'(enc_ch), 0);
        check("mrst_frame_cnt", int'(frame_cnt), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        exp_frames = 8'd0;
        run_frame(24'h000004);
        check("mrst_first_cyc", (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1, 4);
        check("mrst_first_ch", (obs_ch_q.size() > 0) ? obs_ch_q[0] : -1, 2);

        // Frame counter wrap. Disabled frame syncs must not count.
        cnt_before = frame_cnt;
        for (int f = 0; f < 256; f++) begin
            run_frame('0);
            if ((f % 32) == 0) begin
                fs = 1'b1; enable = 1'b0;
                tick();
                fs = 1'b0; enable = 1'b1;
                check("wrap_disabled_fs", int'(busy), 0);
            end
        end
        check("wrap_frame_cnt", int'(frame_cnt), int'(cnt_before));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #5000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
